warp_fetch_scheduler: RTL and testbench

// - Per-warp fetch scheduler in front of the instruction cache; drives the fetcher-side handshake of the multi-warp dispatcher.
// - Holds PC, active mask and a 3-state FSM per warp. Round-robin picks one eligible warp per cycle for a fetch.
// - Reports every accepted fetch to the dispatcher as fe_handshake_o/fe_warp_id_o.

---
 rtl/bgpu_pkg.sv | 16 +
 rtl/fetch_warp_slot.sv | 90 +++++++++
 rtl/warp_fetch_scheduler.sv | 148 ++++++++++++++
 tb/tb_warp_fetch_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgpu_pkg.sv
// rtl/bgpu_pkg.sv - shared warp state type and eligibility helper for the fetch scheduler
package bgpu_pkg;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_READY = 2'd1,
    WS_WAIT  = 2'd2
  } warp_state_e;

  // A warp may be offered to the icache only when it has no fetch in flight
  // and the dispatcher has room in its instruction buffer.
  function automatic logic warp_eligible(warp_state_e state, logic ib_space);
    return (state == WS_READY) && ib_space;
  endfunction

endpackage

// File: rtl/fetch_warp_slot.sv
// rtl/fetch_warp_slot.sv - per-warp fetch state machine with PC and active-mask registers
module fetch_warp_slot
  import bgpu_pkg::*;
#(
  parameter int PcWidth   = 32,
  parameter int WarpWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_en_i,
  input  logic [PcWidth-1:0]   init_pc_i,
  input  logic [WarpWidth-1:0] init_act_mask_i,
  input  logic                 fetch_en_i,
  input  logic                 nxt_en_i,
  input  logic                 nxt_done_i,
  input  logic [PcWidth-1:0]   nxt_pc_i,
  input  logic [WarpWidth-1:0] nxt_act_mask_i,
  input  logic                 ib_space_i,
  output logic                 eligible_o,
  output logic                 active_o,
  output logic [PcWidth-1:0]   pc_o,
  output logic [WarpWidth-1:0] act_mask_o
);

  warp_state_e          state_q, state_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [WarpWidth-1:0] mask_q, mask_d;

  // State, PC and mask registers; everything is dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WS_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic: events that do not match the current state are ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    unique case (state_q)
      WS_IDLE: begin
        if (init_en_i) begin
          state_d = WS_READY;
          pc_d    = init_pc_i;
          mask_d  = init_act_mask_i;
        end
      end
      WS_READY: begin
        if (fetch_en_i) begin
          state_d = WS_WAIT;
        end
      end
      WS_WAIT: begin
        if (nxt_en_i) begin
          if (nxt_done_i) begin
            state_d = WS_IDLE;
          end else begin
            state_d = WS_READY;
            pc_d    = nxt_pc_i;
            mask_d  = nxt_act_mask_i;
          end
        end
      end
      default: begin
        state_d = WS_IDLE;
      end
    endcase
  end

  assign eligible_o = warp_eligible(state_q, ib_space_i);
  assign active_o   = (state_q != WS_IDLE);
  assign pc_o       = pc_q;
  assign act_mask_o = mask_q;

  init_to_busy_warp: assert property (@(posedge clk_i) disable iff (rst_i)
    init_en_i |-> (state_q == WS_IDLE))
    else $error("warp launched while not idle");

  nxt_to_non_waiting_warp: assert property (@(posedge clk_i) disable iff (rst_i)
    nxt_en_i |-> (state_q == WS_WAIT))
    else $error("next-pc resolution for a warp with no fetch in flight");

endmodule

// File: rtl/warp_fetch_scheduler.sv
// rtl/warp_fetch_scheduler.sv - round-robin per-warp fetch scheduler; WARP_FETCH_SCHED_PERF_EN enables perf counters
module warp_fetch_scheduler
  import bgpu_pkg::*;
#(
  parameter int NumWarps  = 8,
  parameter int PcWidth   = 32,
  parameter int WarpWidth = 32,
  localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumWarps-1:0]  ib_space_available_i,
  input  logic                 init_valid_i,
  input  logic [WidWidth-1:0]  init_warp_id_i,
  input  logic [PcWidth-1:0]   init_pc_i,
  input  logic [WarpWidth-1:0] init_act_mask_i,
  output logic                 ic_valid_o,
  input  logic                 ic_ready_i,
  output logic [PcWidth-1:0]   ic_pc_o,
  output logic [WarpWidth-1:0] ic_act_mask_o,
  output logic [WidWidth-1:0]  ic_warp_id_o,
  output logic                 fe_handshake_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  input  logic                 nxt_valid_i,
  input  logic [WidWidth-1:0]  nxt_warp_id_i,
  input  logic [PcWidth-1:0]   nxt_pc_i,
  input  logic [WarpWidth-1:0] nxt_act_mask_i,
  input  logic                 nxt_done_i,
  output logic [NumWarps-1:0]  warp_active_o,
  output logic                 all_done_o,
  output logic [31:0]          perf_fetches_o,
  output logic [31:0]          perf_stall_cycles_o
);

  logic [NumWarps-1:0]  eligible;
  logic [NumWarps-1:0]  init_en;
  logic [NumWarps-1:0]  fetch_en;
  logic [NumWarps-1:0]  nxt_en;
  logic [PcWidth-1:0]   slot_pc   [NumWarps];
  logic [WarpWidth-1:0] slot_mask [NumWarps];

  logic [WidWidth-1:0]  rr_ptr_q;
  logic                 locked_q;
  logic [WidWidth-1:0]  lock_id_q;
  logic [NumWarps-1:0]  upper_req;
  logic [WidWidth-1:0]  upper_id;
  logic [WidWidth-1:0]  any_id;
  logic [WidWidth-1:0]  arb_id;
  logic [WidWidth-1:0]  grant_id;

  for (genvar w = 0; w < NumWarps; w++) begin : gen_slot
    assign init_en[w]  = init_valid_i && (init_warp_id_i == WidWidth'(w));
    assign fetch_en[w] = fe_handshake_o && (grant_id == WidWidth'(w));
    assign nxt_en[w]   = nxt_valid_i && (nxt_warp_id_i == WidWidth'(w));

    fetch_warp_slot #(
      .PcWidth   (PcWidth),
      .WarpWidth (WarpWidth)
    ) i_slot (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .init_en_i       (init_en[w]),
      .init_pc_i       (init_pc_i),
      .init_act_mask_i (init_act_mask_i),
      .fetch_en_i      (fetch_en[w]),
      .nxt_en_i        (nxt_en[w]),
      .nxt_done_i      (nxt_done_i),
      .nxt_pc_i        (nxt_pc_i),
      .nxt_act_mask_i  (nxt_act_mask_i),
      .ib_space_i      (ib_space_available_i[w]),
      .eligible_o      (eligible[w]),
      .active_o        (warp_active_o[w]),
      .pc_o            (slot_pc[w]),
      .act_mask_o      (slot_mask[w])
    );
  end

  // Round-robin pick: lowest eligible warp at or above the pointer, else lowest overall.
  always_comb begin
    upper_req = '0;
    upper_id  = '0;
    any_id    = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      upper_req[i] = eligible[i] && (WidWidth'(i) >= rr_ptr_q);
      if (upper_req[i]) begin
        upper_id = WidWidth'(i);
      end
      if (eligible[i]) begin
        any_id = WidWidth'(i);
      end
    end
    arb_id = (|upper_req) ? upper_id : any_id;
  end

  // A stalled request keeps its grant so the icache sees stable payload until it accepts.
  assign grant_id       = locked_q ? lock_id_q : arb_id;
  assign ic_valid_o     = locked_q || (|eligible);
  assign ic_warp_id_o   = grant_id;
  assign ic_pc_o        = slot_pc[grant_id];
  assign ic_act_mask_o  = slot_mask[grant_id];
  assign fe_handshake_o = ic_valid_o && ic_ready_i;
  assign fe_warp_id_o   = ic_warp_id_o;
  assign all_done_o     = ~|warp_active_o;

  // Arbiter state: pointer moves past the winner only on an accepted fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      if (fe_handshake_o) begin
        rr_ptr_q <= (grant_id == WidWidth'(NumWarps - 1)) ? '0 : grant_id + WidWidth'(1);
        locked_q <= 1'b0;
      end else if (ic_valid_o) begin
        locked_q  <= 1'b1;
        lock_id_q <= grant_id;
      end
    end
  end

`ifdef WARP_FETCH_SCHED_PERF_EN
  logic [31:0] fetches_q;
  logic [31:0] stalls_q;

  // Free-running wrapping counters of accepted fetches and back-pressured cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetches_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (fe_handshake_o) begin
        fetches_q <= fetches_q + 32'd1;
      end
      if (ic_valid_o && !ic_ready_i) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign perf_fetches_o      = fetches_q;
  assign perf_stall_cycles_o = stalls_q;
`else
  assign perf_fetches_o      = '0;
  assign perf_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// tb/tb_warp_fetch_scheduler.sv - scoreboard bench for warp_fetch_scheduler
module tb_warp_fetch_scheduler;

  localparam int NW = 8;
  localparam int PW = 32;
  localparam int MW = 32;
  localparam int WW = 3;
`ifdef WARP_FETCH_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] ib_space;
  logic          init_valid;
  logic [WW-1:0] init_warp_id;
  logic [PW-1:0] init_pc;
  logic [MW-1:0] init_mask;
  logic          ic_valid;
  logic          ic_ready;
  logic [PW-1:0] ic_pc;
  logic [MW-1:0] ic_mask;
  logic [WW-1:0] ic_warp_id;
  logic          fe_handshake;
  logic [WW-1:0] fe_warp_id;
  logic          nxt_valid;
  logic [WW-1:0] nxt_warp_id;
  logic [PW-1:0] nxt_pc;
  logic [MW-1:0] nxt_mask;
  logic          nxt_done;
  logic [NW-1:0] warp_active;
  logic          all_done;
  logic [31:0]   perf_fetches;
  logic [31:0]   perf_stalls;

  typedef struct packed {
    logic [WW-1:0] id;
    logic [PW-1:0] pc;
    logic [MW-1:0] mask;
  } fetch_t;

  fetch_t exp_q[$];
  fetch_t mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;

  warp_fetch_scheduler dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .ib_space_available_i (ib_space),
    .init_valid_i         (init_valid),
    .init_warp_id_i       (init_warp_id),
    .init_pc_i            (init_pc),
    .init_act_mask_i      (init_mask),
    .ic_valid_o           (ic_valid),
    .ic_ready_i           (ic_ready),
    .ic_pc_o              (ic_pc),
    .ic_act_mask_o        (ic_mask),
    .ic_warp_id_o         (ic_warp_id),
    .fe_handshake_o       (fe_handshake),
    .fe_warp_id_o         (fe_warp_id),
    .nxt_valid_i          (nxt_valid),
    .nxt_warp_id_i        (nxt_warp_id),
    .nxt_pc_i             (nxt_pc),
    .nxt_act_mask_i       (nxt_mask),
    .nxt_done_i           (nxt_done),
    .warp_active_o        (warp_active),
    .all_done_o           (all_done),
    .perf_fetches_o       (perf_fetches),
    .perf_stall_cycles_o  (perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && ic_valid && ic_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fetch: got warp %0d pc 0x%0h, expected no fetch", ic_warp_id, ic_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch", {fe_handshake, fe_warp_id, ic_warp_id, ic_pc, ic_mask},
              {1'b1, mon_e.id, mon_e.id, mon_e.pc, mon_e.mask});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic expect_fetch(input int id, input logic [PW-1:0] pc, input logic [MW-1:0] mask);
    fetch_t e;
    e.id   = WW'(id);
    e.pc   = pc;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    ib_space     = '1;
    init_valid   = 1'b0;
    init_warp_id = '0;
    init_pc      = '0;
    init_mask    = '0;
    ic_ready     = 1'b1;
    nxt_valid    = 1'b0;
    nxt_warp_id  = '0;
    nxt_pc       = '0;
    nxt_mask     = '0;
    nxt_done     = 1'b0;
    step();
    step();
    settle();
    rst = 1'b0;
  endtask

  task automatic drive_init(input int id, input logic [PW-1:0] pc, input logic [MW-1:0] mask);
    init_valid   = 1'b1;
    init_warp_id = WW'(id);
    init_pc      = pc;
    init_mask    = mask;
  endtask

  task automatic drive_nxt(input int id, input logic [PW-1:0] pc, input logic [MW-1:0] mask, input logic done);
    nxt_valid   = 1'b1;
    nxt_warp_id = WW'(id);
    nxt_pc      = pc;
    nxt_mask    = mask;
    nxt_done    = done;
  endtask

  int             grant_tbl [6] = '{0, 1, 3, 0, 1, 3};
  logic [PW-1:0]  base_pc   [NW];
  logic [MW-1:0]  base_mask [NW];

  initial begin
    // Reset state
    do_reset();
    rst = 1'b1;
    step();
    settle();
    check("reset_ic_valid", ic_valid, 0);
    check("reset_handshake", fe_handshake, 0);
    check("reset_warp_active", warp_active, 0);
    check("reset_all_done", all_done, 1);
    check("reset_perf", {perf_fetches, perf_stalls}, 0);
    rst = 1'b0;

    // Launch warp 2: request appears once it is READY
    step();
    drive_init(2, 32'h100, 32'hFFFF_FFFF);
    expect_fetch(2, 32'h100, 32'hFFFF_FFFF);
    settle();
    check("init_cycle_no_valid", ic_valid, 0);
    step();
    init_valid = 1'b0;
    settle();
    check("w2_valid", ic_valid, 1);
    step();
    settle();
    check("w2_wait_active", warp_active, 8'h04);
    check("w2_no_refetch", ic_valid, 0);
    drive_nxt(2, 32'h0, 32'h0, 1'b1);
    step();
    nxt_valid = 1'b0;
    settle();
    check("w2_done_all_done", {warp_active, all_done}, {8'h00, 1'b1});

    // Round-robin over warps 0,1,3 with next-pc returned one cycle after each fetch
    do_reset();
    base_pc[0] = 32'h1000; base_mask[0] = 32'h0000_00FF;
    base_pc[1] = 32'h2000; base_mask[1] = 32'hFFFF_0000;
    base_pc[3] = 32'h3000; base_mask[3] = 32'h0000_0001;
    ib_space = '0;
    step();
    drive_init(0, base_pc[0], base_mask[0]);
    step();
    drive_init(1, base_pc[1], base_mask[1]);
    step();
    drive_init(3, base_pc[3], base_mask[3]);
    step();
    init_valid = 1'b0;
    settle();
    check("rr_no_space_no_req", {warp_active, ic_valid}, {8'b0000_1011, 1'b0});
    for (int k = 0; k < 6; k++) begin
      if (k < 3) expect_fetch(grant_tbl[k], base_pc[grant_tbl[k]], base_mask[grant_tbl[k]]);
      else       expect_fetch(grant_tbl[k], base_pc[grant_tbl[k]] + 32'd4, ~base_mask[grant_tbl[k]]);
    end
    step();
    ib_space = '1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        nxt_valid = 1'b0;
      end else if (c - 1 < 3) begin
        drive_nxt(grant_tbl[c-1], base_pc[grant_tbl[c-1]] + 32'd4, ~base_mask[grant_tbl[c-1]], 1'b0);
      end else begin
        drive_nxt(grant_tbl[c-1], 32'h0, 32'h0, 1'b1);
      end
      settle();
      if (c < 6) check($sformatf("rr_valid_c%0d", c), ic_valid, 1);
      step();
    end
    nxt_valid = 1'b0;
    settle();
    check("rr_all_done", {all_done, ic_valid}, {1'b1, 1'b0});

    // Back-pressure: warp 5 request held stable while warp 1 launches
    do_reset();
    step();
    ic_ready = 1'b0;
    drive_init(5, 32'h500, 32'hA5A5_A5A5);
    expect_fetch(5, 32'h500, 32'hA5A5_A5A5);
    step();
    init_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) drive_init(1, 32'h110, 32'h0000_FFFF);
      settle();
      check($sformatf("stall_hold_s%0d", s), {ic_valid, ic_warp_id, ic_pc, ic_mask},
            {1'b1, 3'd5, 32'h500, 32'hA5A5_A5A5});
      step();
      init_valid = 1'b0;
    end
    ic_ready = 1'b1;
    expect_fetch(1, 32'h110, 32'h0000_FFFF);
    settle();
    check("stall_locked_after_init", ic_warp_id, 5);
    check("stall_count", perf_stalls, PERF ? 32'd4 : 32'd0);
    step();
    settle();
    check("stall_next_warp1", ic_warp_id, 1);
    check("fetch_count", perf_fetches, PERF ? 32'd1 : 32'd0);
    step();

    // Instruction-buffer space gating on warp 4
    do_reset();
    ib_space = 8'hEF;
    step();
    drive_init(4, 32'h400, 32'h0F0F_0F0F);
    step();
    init_valid = 1'b0;
    settle();
    check("no_space_no_req_a", ic_valid, 0);
    step();
    settle();
    check("no_space_no_req_b", ic_valid, 0);
    step();
    expect_fetch(4, 32'h400, 32'h0F0F_0F0F);
    ib_space = '1;
    settle();
    check("space_req", ic_valid, 1);
    step();

    // Exit: warp 6 retires, then warp 4 retires
    drive_init(6, 32'h600, 32'h0000_0003);
    expect_fetch(6, 32'h600, 32'h0000_0003);
    step();
    init_valid = 1'b0;
    step();
    settle();
    check("exit_both_wait", warp_active, 8'h50);
    drive_nxt(6, 32'h0, 32'h0, 1'b1);
    step();
    nxt_valid = 1'b0;
    settle();
    check("exit_w6_idle", {warp_active, all_done}, {8'h10, 1'b0});
    drive_nxt(4, 32'h0, 32'h0, 1'b1);
    step();
    nxt_valid = 1'b0;
    settle();
    check("exit_all_done", {warp_active, all_done}, {8'h00, 1'b1});

    // Handshake on warp 0 together with next-pc for warp 7
    do_reset();
    ib_space = 8'h80;
    step();
    drive_init(7, 32'h70, 32'h0000_0007);
    expect_fetch(7, 32'h70, 32'h0000_0007);
    step();
    drive_init(0, 32'h80, 32'h0000_0001);
    step();
    init_valid = 1'b0;
    settle();
    check("same_cycle_setup", {warp_active, ic_valid}, {8'h81, 1'b0});
    ib_space = '1;
    drive_nxt(7, 32'h40, 32'h0000_FF00, 1'b0);
    expect_fetch(0, 32'h80, 32'h0000_0001);
    expect_fetch(7, 32'h40, 32'h0000_FF00);
    settle();
    check("same_cycle_w0_req", {ic_valid, ic_warp_id}, {1'b1, 3'd0});
    step();
    nxt_valid = 1'b0;
    settle();
    check("same_cycle_w7_next", {ic_valid, ic_warp_id, ic_pc, warp_active}, {1'b1, 3'd7, 32'h40, 8'h81});
    step();
    settle();
    check("same_cycle_quiet", ic_valid, 0);

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
